// File: rtl/demux_pkg.sv
// Shared constants for demux_stream: channel indices, select codes and slot states.
// The select codes mirror the team 4:1 mux so both blocks agree on channel numbering.
package demux_pkg;

    localparam int NUM_CH = 4;

    localparam int CH_OUT1 = 0;
    localparam int CH_OUT2 = 1;
    localparam int CH_OUT3 = 2;
    localparam int CH_OUT4 = 3;

    localparam logic [1:0] SEL_OUT1 = 2'b01;
    localparam logic [1:0] SEL_OUT2 = 2'b00;
    localparam logic [1:0] SEL_OUT3 = 2'b11;
    localparam logic [1:0] SEL_OUT4 = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Channel index addressed by a select code.
    function automatic logic [1:0] sel_to_ch(input logic [1:0] sel);
        logic [1:0] ch;
        ch = 2'(CH_OUT2);
        case (sel)
            SEL_OUT1: ch = 2'(CH_OUT1);
            SEL_OUT2: ch = 2'(CH_OUT2);
            SEL_OUT3: ch = 2'(CH_OUT3);
            SEL_OUT4: ch = 2'(CH_OUT4);
            default:  ch = 2'(CH_OUT2);
        endcase
        return ch;
    endfunction

    function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [1:0] sel);
        logic [NUM_CH-1:0] base;
        base = 4'b0001;
        return base << sel_to_ch(sel);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with EMPTY/FULL state and same-cycle replace.
// With DEMUX_CNT_EN defined, also keeps a wrapping drain counter with synchronous clear.
module demux_slot
    import demux_pkg::*;
#(
`ifdef DEMUX_CNT_EN
    parameter int CW = 8,
`endif
    parameter int W  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef DEMUX_CNT_EN
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt,
`endif
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          out_ready,
    output logic          valid,
    output logic [W-1:0]  data
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         drain;

    assign valid = (state_q == FULL);
    assign data  = data_q;
    assign drain = valid && out_ready;

    // A load always wins: it either fills an empty slot or replaces the word being drained.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (drain) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/demux_stream.sv
// 1-to-4 valid/ready demultiplexer routing each word to one of four registered slots.
// Optional per-channel drain counters are enabled by defining DEMUX_CNT_EN.
module demux_stream
    import demux_pkg::*;
#(
`ifdef DEMUX_CNT_EN
    parameter int CW = 8,
`endif
    parameter int W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef DEMUX_CNT_EN
    input  logic                 cnt_clr,
    output logic [NUM_CH*CW-1:0] out_cnt,
`endif
    input  logic                 in_valid,
    input  logic [1:0]           in_sel,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [NUM_CH*W-1:0]  out_data,
    input  logic [NUM_CH-1:0]    out_ready
);

    logic [1:0]        target_ch;
    logic [NUM_CH-1:0] target_oh;
    logic [NUM_CH-1:0] load;
    logic              accept;

    // Only the addressed slot can stall the input; in_data never reaches in_ready.
    always_comb begin
        target_ch = sel_to_ch(in_sel);
        target_oh = sel_to_onehot(in_sel);
        in_ready  = !out_valid[target_ch] || out_ready[target_ch];
        accept    = in_valid && in_ready;
        load      = accept ? target_oh : '0;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
`ifdef DEMUX_CNT_EN
            .CW        (CW),
`endif
            .W         (W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef DEMUX_CNT_EN
            .cnt_clr   (cnt_clr),
            .cnt       (out_cnt[k*CW +: CW]),
`endif
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*W +: W])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: per-channel queue model plus directed literal checks.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux_stream;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [1:0]     in_sel = 2'b00;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [3:0]     out_valid;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_ready = 4'b0000;
`ifdef DEMUX_CNT_EN
    localparam int CW = 8;
    logic           cnt_clr = 1'b0;
    logic [4*CW-1:0] out_cnt;
`endif

    demux_stream #(
`ifdef DEMUX_CNT_EN
        .CW        (CW),
`endif
        .W         (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_CNT_EN
        .cnt_clr   (cnt_clr),
        .out_cnt   (out_cnt),
`endif
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int total_checks = 0;
    int bad_checks   = 0;

    // Channel reached by each select value: sel 00->out2, 01->out1, 10->out4, 11->out3.
    int chan_of_sel [4] = '{1, 0, 3, 2};

    logic [W-1:0] sb_q [4][$];
    int accepted = 0;
    int drained  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [W-1:0] data,
                                 input logic [3:0] ready);
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: one queue per channel; drains pop, accepts push, all decided on inputs before the edge.
    always @(posedge clk or negedge rst_n) begin : model
        int  t;
        bit  acc;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) sb_q[k].delete();
            accepted = 0;
            drained  = 0;
        end else begin
            t   = chan_of_sel[in_sel];
            acc = in_valid && (sb_q[t].size() == 0 || out_ready[t]);
            for (int k = 0; k < 4; k++) begin
                if (sb_q[k].size() > 0 && out_ready[k]) begin
                    void'(sb_q[k].pop_front());
                    drained++;
                end
            end
            if (acc) begin
                sb_q[t].push_back(in_data);
                accepted++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] ev;
        int         t;
        logic       er;
        if (!rst_n) begin
            checkOutput("reset_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_data", 32'(out_data), 32'd0);
        end else begin
            for (int k = 0; k < 4; k++) ev[k] = (sb_q[k].size() > 0);
            checkOutput("model_valid", 32'(out_valid), 32'(ev));
            for (int k = 0; k < 4; k++) begin
                if (ev[k]) checkOutput("model_data", 32'(out_data[k*W +: W]), 32'(sb_q[k][0]));
            end
            t  = chan_of_sel[in_sel];
            er = (sb_q[t].size() == 0) || out_ready[t];
            checkOutput("model_ready", 32'(in_ready), 32'(er));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("post_reset_valid", 32'(out_valid), 32'h0);

        applyStimulus(1'b1, 2'b01, 2'b00, 4'b1111); step();
        checkOutput("route_out1_valid", 32'(out_valid), 32'h1);
        checkOutput("route_out1_data", 32'(out_data[1:0]), 32'h0);
        applyStimulus(1'b1, 2'b00, 2'b01, 4'b1111); step();
        checkOutput("route_out2_valid", 32'(out_valid), 32'h2);
        checkOutput("route_out2_data", 32'(out_data[3:2]), 32'h1);
        applyStimulus(1'b1, 2'b11, 2'b10, 4'b1111); step();
        checkOutput("route_out3_valid", 32'(out_valid), 32'h4);
        checkOutput("route_out3_data", 32'(out_data[5:4]), 32'h2);
        applyStimulus(1'b1, 2'b10, 2'b11, 4'b1111); step();
        checkOutput("route_out4_valid", 32'(out_valid), 32'h8);
        checkOutput("route_all_data", 32'(out_data), 32'hE4);

        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1110); step();
        checkOutput("bp_idle_valid", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 2'b01, 2'b10, 4'b1110); step();
        checkOutput("bp_first_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_first_data", 32'(out_data[1:0]), 32'h2);
        applyStimulus(1'b1, 2'b01, 2'b11, 4'b1110); #1;
        checkOutput("bp_stall_ready", 32'(in_ready), 32'h0);
        step();
        checkOutput("bp_hold_data", 32'(out_data[1:0]), 32'h2);
        applyStimulus(1'b1, 2'b01, 2'b11, 4'b1111); #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
        step();
        checkOutput("bp_replace_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_replace_data", 32'(out_data[1:0]), 32'h3);

        applyStimulus(1'b0, 2'b01, 2'b00, 4'b1110); step();
        checkOutput("stall_hold_data", 32'(out_data[1:0]), 32'h3);
        applyStimulus(1'b1, 2'b11, 2'b10, 4'b1110); #1;
        checkOutput("indep_ready", 32'(in_ready), 32'h1);
        step();
        checkOutput("indep_valid", 32'(out_valid), 32'h5);
        checkOutput("indep_out3_data", 32'(out_data[5:4]), 32'h2);
        checkOutput("indep_out1_data", 32'(out_data[1:0]), 32'h3);
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1110); step();
        checkOutput("indep_drain_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1111); step();

        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          W'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            step();
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1111); step(); step();
        checkOutput("stress_flushed", 32'(out_valid), 32'h0);
        checkOutput("stress_no_loss", 32'(drained), 32'(accepted));

        applyStimulus(1'b1, 2'b01, 2'b01, 4'b0000); step();
        applyStimulus(1'b1, 2'b11, 2'b10, 4'b0000); step();
        checkOutput("mid_full_valid", 32'(out_valid), 32'h5);
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(out_valid), 32'h0);
        checkOutput("async_reset_data", 32'(out_data), 32'h0);
        step(); step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1111); step();
        checkOutput("no_replay_valid", 32'(out_valid), 32'h0);

`ifdef DEMUX_CNT_EN
        applyStimulus(1'b1, 2'b00, 2'b01, 4'b1111);
        repeat (260) step();
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1111); step();
        checkOutput("cnt_out2_wrap", 32'(out_cnt[15:8]), 32'd4);
        checkOutput("cnt_out1_idle", 32'(out_cnt[7:0]), 32'd0);
        applyStimulus(1'b1, 2'b00, 2'b10, 4'b1111); step();
        applyStimulus(1'b0, 2'b00, 2'b00, 4'b1111);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checkOutput("cnt_clr_priority", 32'(out_cnt[15:8]), 32'd0);
        checkOutput("cnt_clr_drained", 32'(out_valid), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
